time_set_controller: RTL

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// time_set_controller: RUN / SET_H / SET_M mode FSM with
// increment auto-repeat, idle timeout and field blink.
module time_set_controller #(
  parameter int HOLD_TICKS    = 50,
  parameter int REPEAT_TICKS  = 10,
  parameter int TIMEOUT_TICKS = 3000,
  parameter int BLINK_TICKS   = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_mode,
  input  logic btn_inc,
  output logic run_en,
  output logic set_hours,
  output logic set_minutes,
  output logic inc_hours,
  output logic inc_minutes,
  output logic clr_seconds,
  output logic blink
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic mode_q, inc_q, armed_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;
  logic [TW-1:0] idle_q;
  logic [BW-1:0] blk_q;
  logic blink_q, inc_h_q, inc_m_q, clr_q;

  logic mode_ev, inc_ev, in_set, held;
  logic hold_done, rep_ev, timeout;
  logic chg, inc_req;

  // Button edge events, hold/repeat strobe and idle timeout.
  always_comb begin
    mode_ev   = btn_mode & ~mode_q;
    inc_ev    = btn_inc & ~inc_q & armed_q;
    in_set    = state_q != RUN;
    held      = in_set & btn_inc & armed_q;
    hold_done = hold_q == HOLD_MAX;
    rep_ev    = 1'b0;
    if (held && tick)
      rep_ev = hold_done ? (rep_q == REP_LAST)
                         : (hold_q == HOLD_LAST);
    timeout = in_set & tick & (idle_q == IDLE_LAST)
            & ~mode_ev & ~inc_ev & ~rep_ev;
  end

  // Next state; mode press wins over inc and timeout.
  always_comb begin
    state_d = state_q;
    if (mode_ev) begin
      unique case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end
    chg     = state_d != state_q;
    inc_req = (inc_ev | rep_ev) & ~chg;
  end

  // State, button registers and inc arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      if (!btn_inc)
        armed_q <= 1'b1;
      else if (chg)
        armed_q <= 1'b0;
    end
  end

  // Hold-to-first-repeat then repeat-interval tick counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (!held || chg) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else if (tick) begin
      if (!hold_done)
        hold_q <= hold_q + 1'b1;
      else if (rep_ev)
        rep_q <= '0;
      else
        rep_q <= rep_q + 1'b1;
    end
  end

  // Idle tick counter, restarted by any activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_q <= '0;
    else if (chg || mode_ev || inc_ev || rep_ev || !in_set)
      idle_q <= '0;
    else if (tick && idle_q != IDLE_MAX)
      idle_q <= idle_q + 1'b1;
  end

  // Blink starts high on entry and toggles each half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
      blk_q   <= '0;
    end else if (chg) begin
      blink_q <= state_d != RUN;
      blk_q   <= '0;
    end else if (!in_set) begin
      blink_q <= 1'b0;
      blk_q   <= '0;
    end else if (tick) begin
      if (blk_q == BLK_LAST) begin
        blink_q <= ~blink_q;
        blk_q   <= '0;
      end else begin
        blk_q <= blk_q + 1'b1;
      end
    end
  end

  // Registered one-cycle increment and clear pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_h_q <= 1'b0;
      inc_m_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      inc_h_q <= inc_req & (state_q == SET_H);
      inc_m_q <= inc_req & (state_q == SET_M);
      clr_q   <= mode_ev & (state_q == SET_M);
    end
  end

  assign run_en      = state_q == RUN;
  assign set_hours   = state_q == SET_H;
  assign set_minutes = state_q == SET_M;
  assign inc_hours   = inc_h_q;
  assign inc_minutes = inc_m_q;
  assign clr_seconds = clr_q;
  assign blink       = blink_q;

endmodule
